hub_norm_ctrl: RTL and testbench

HUB_NORM_CTRL -- requirements
Module: hub_norm_ctrl

---
 rtl/hub_norm_ctrl.sv | 164 ++++++++++++++++
 tb/tb_hub_norm_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/hub_norm_ctrl.sv
// Post-add mantissa normalizer driven by an anticipated leading-zero count.
// Define HUB_NORM_ITER_SHIFT_EN for a GROUP_SIZE-bit-per-cycle iterative shifter.
module hub_norm_ctrl #(
  parameter int M           = 24,
  parameter int E           = 8,
  parameter int GROUP_SIZE  = 5,
  parameter int SHIFT_WIDTH = $clog2(M)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [M:0]             in_mant,
  input  logic [E-1:0]           in_exp,
  input  logic [SHIFT_WIDTH-1:0] in_lz,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [M:0]             out_mant,
  output logic [E-1:0]           out_exp,
  output logic                   out_zero,
  output logic                   out_uf,
  output logic                   out_corr
);

  localparam int CW = ((E > SHIFT_WIDTH) ? E : SHIFT_WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CORR,
    DONE
  } state_t;

  state_t                 state_q;
  logic [M:0]             mant_q;
  logic [E-1:0]           exp_q;
  logic [SHIFT_WIDTH-1:0] cnt_q;

  logic                   out_valid_q;
  logic [M:0]             out_mant_q;
  logic [E-1:0]           out_exp_q;
  logic                   out_zero_q;
  logic                   out_uf_q;
  logic                   out_corr_q;

  logic                   accept;
  logic [SHIFT_WIDTH-1:0] lzc_d;
  logic                   uf_d;
  logic [SHIFT_WIDTH-1:0] sh_amt_d;
  logic [M:0]             sh_mant_d;
  logic [E-1:0]           sh_exp_d;
  logic [SHIFT_WIDTH-1:0] cnt_d;

  assign in_ready  = (state_q == IDLE);
  assign accept    = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign out_mant  = out_mant_q;
  assign out_exp   = out_exp_q;
  assign out_zero  = out_zero_q;
  assign out_uf    = out_uf_q;
  assign out_corr  = out_corr_q;

  always_comb begin
    lzc_d = in_lz;
    if (CW'(in_lz) > CW'(M)) lzc_d = SHIFT_WIDTH'(M);
    uf_d = (CW'(lzc_d) >= CW'(in_exp));
  end

  // cnt_q is the remaining shift in iterative mode, the full lzc otherwise
  always_comb begin
`ifdef HUB_NORM_ITER_SHIFT_EN
    if (CW'(cnt_q) < CW'(GROUP_SIZE)) sh_amt_d = cnt_q;
    else                               sh_amt_d = SHIFT_WIDTH'(GROUP_SIZE);
`else
    sh_amt_d = cnt_q;
`endif
    sh_mant_d = mant_q << sh_amt_d;
    sh_exp_d  = exp_q - E'(sh_amt_d);
    cnt_d     = cnt_q - sh_amt_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mant_q      <= '0;
      exp_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_mant_q  <= '0;
      out_exp_q   <= '0;
      out_zero_q  <= 1'b0;
      out_uf_q    <= 1'b0;
      out_corr_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            mant_q <= in_mant;
            exp_q  <= in_exp;
            cnt_q  <= lzc_d;
            if (in_mant == '0) begin
              out_valid_q <= 1'b1;
              out_mant_q  <= '0;
              out_exp_q   <= '0;
              out_zero_q  <= 1'b1;
              out_uf_q    <= 1'b0;
              out_corr_q  <= 1'b0;
              state_q     <= DONE;
            end else if (uf_d) begin
              out_valid_q <= 1'b1;
              out_mant_q  <= '0;
              out_exp_q   <= '0;
              out_zero_q  <= 1'b0;
              out_uf_q    <= 1'b1;
              out_corr_q  <= 1'b0;
              state_q     <= DONE;
            end else begin
              state_q <= SHIFT;
            end
          end
        end
        SHIFT: begin
          mant_q <= sh_mant_d;
          exp_q  <= sh_exp_d;
          cnt_q  <= cnt_d;
`ifdef HUB_NORM_ITER_SHIFT_EN
          if (cnt_d == '0) state_q <= CORR;
`else
          state_q <= CORR;
`endif
        end
        CORR: begin
          out_valid_q <= 1'b1;
          out_zero_q  <= 1'b0;
          state_q     <= DONE;
          if (mant_q[M]) begin
            out_mant_q <= mant_q;
            out_exp_q  <= exp_q;
            out_uf_q   <= 1'b0;
            out_corr_q <= 1'b0;
          end else if (exp_q == E'(1)) begin
            out_mant_q <= '0;
            out_exp_q  <= '0;
            out_uf_q   <= 1'b1;
            out_corr_q <= 1'b0;
          end else begin
            out_mant_q <= mant_q << 1;
            out_exp_q  <= exp_q - E'(1);
            out_uf_q   <= 1'b0;
            out_corr_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hub_norm_ctrl.sv
// Directed bench for hub_norm_ctrl (M=24, E=8, GROUP_SIZE=5).
// Latency expectations follow HUB_NORM_ITER_SHIFT_EN when defined.
module tb_hub_norm_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [24:0] in_mant;
  logic [7:0]  in_exp;
  logic [4:0]  in_lz;
  logic        out_valid;
  logic        out_ready;
  logic [24:0] out_mant;
  logic [7:0]  out_exp;
  logic        out_zero;
  logic        out_uf;
  logic        out_corr;

  int total = 0;
  int bad   = 0;

  hub_norm_ctrl #(
    .M(24), .E(8), .GROUP_SIZE(5), .SHIFT_WIDTH(5)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mant(in_mant), .in_exp(in_exp), .in_lz(in_lz),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mant(out_mant), .out_exp(out_exp),
    .out_zero(out_zero), .out_uf(out_uf), .out_corr(out_corr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic int nlat(input int lzc);
`ifdef HUB_NORM_ITER_SHIFT_EN
    int occ;
    occ = (lzc + 4) / 5;
    if (occ < 1) occ = 1;
    return 2 + occ;
`else
    return 3;
`endif
  endfunction

  // entered at a negedge with the DUT idle; returns at the out_valid negedge
  task automatic req(input logic [24:0] m, input logic [7:0] e,
                     input logic [4:0] lz, output int lat);
    chk("rdy_pre", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_mant  = m;
    in_exp   = e;
    in_lz    = lz;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_mant  = 25'($urandom);
    in_exp   = 8'($urandom);
    in_lz    = 5'($urandom);
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("rdy_post", 64'(in_ready), 64'd1);
  endtask

  task automatic vec(input string tag,
                     input logic [24:0] m, input logic [7:0] e,
                     input logic [4:0] lz,
                     input logic [24:0] em, input logic [7:0] ee,
                     input logic z, input logic u, input logic c,
                     input int elat);
    int lat;
    req(m, e, lz, lat);
    chk({tag, "_lat"},  64'(lat), 64'(elat));
    chk({tag, "_mant"}, 64'(out_mant), 64'(em));
    chk({tag, "_exp"},  64'(out_exp), 64'(ee));
    chk({tag, "_flags"}, 64'({out_zero, out_uf, out_corr}),
        64'({z, u, c}));
    consume();
  endtask

  initial begin
    int lat;
    logic seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_mant   = '0;
    in_exp    = '0;
    in_lz     = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_rdy",   64'(in_ready), 64'd1);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_outs",  64'({out_mant, out_exp, out_zero, out_uf, out_corr}),
        64'd0);

    vec("norm",  25'h0400000, 8'd100, 5'd2,  25'h1000000, 8'd98,
        1'b0, 1'b0, 1'b0, nlat(2));
    vec("corr",  25'h0200000, 8'd100, 5'd2,  25'h1000000, 8'd97,
        1'b0, 1'b0, 1'b1, nlat(2));
    vec("zero",  25'h0000000, 8'd55,  5'd3,  25'h0, 8'd0,
        1'b1, 1'b0, 1'b0, 1);
    vec("uf",    25'h0400000, 8'd3,   5'd5,  25'h0, 8'd0,
        1'b0, 1'b1, 1'b0, 1);
    vec("uf_eq", 25'h0080000, 8'd5,   5'd5,  25'h0, 8'd0,
        1'b0, 1'b1, 1'b0, 1);
    vec("exp1",  25'h0080000, 8'd6,   5'd5,  25'h1000000, 8'd1,
        1'b0, 1'b0, 1'b0, nlat(5));
    vec("cflush", 25'h0040000, 8'd6,  5'd5,  25'h0, 8'd0,
        1'b0, 1'b1, 1'b0, nlat(5));
    vec("clamp", 25'h0000001, 8'd100, 5'd31, 25'h1000000, 8'd76,
        1'b0, 1'b0, 1'b0, nlat(24));
    vec("cl_uf", 25'h0000001, 8'd20,  5'd31, 25'h0, 8'd0,
        1'b0, 1'b1, 1'b0, 1);
    vec("msb0",  25'h0100000, 8'd100, 5'd2,  25'h0800000, 8'd97,
        1'b0, 1'b0, 1'b1, nlat(2));
    vec("lz0",   25'h1abcdef, 8'd9,   5'd0,  25'h1abcdef, 8'd9,
        1'b0, 1'b0, 1'b0, nlat(0));
    // bit 11 + 12 lands on bit 23, so one correction shift follows
    vec("iter",  25'h0000800, 8'd50,  5'd12, 25'h1000000, 8'd37,
        1'b0, 1'b0, 1'b1, nlat(12));

    req(25'h0400000, 8'd100, 5'd2, lat);
    chk("hold_lat", 64'(lat), 64'(nlat(2)));
    for (int i = 0; i < 5; i++) begin
      chk("hold_vld", 64'(out_valid), 64'd1);
      chk("hold_rdy", 64'(in_ready), 64'd0);
      chk("hold_out", 64'({out_mant, out_exp, out_zero, out_uf, out_corr}),
          64'({25'h1000000, 8'd98, 3'b000}));
      @(negedge clk);
    end
    consume();
    vec("b2b", 25'h0200000, 8'd100, 5'd2, 25'h1000000, 8'd97,
        1'b0, 1'b0, 1'b1, nlat(2));

    in_valid = 1'b1;
    in_mant  = 25'h0400000;
    in_exp   = 8'd100;
    in_lz    = 5'd2;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mrst_rdy",  64'(in_ready), 64'd1);
    chk("mrst_outs", 64'({out_valid, out_mant, out_exp,
                          out_zero, out_uf, out_corr}), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) seen = 1'b1;
      @(negedge clk);
    end
    chk("mrst_novld", 64'(seen), 64'd0);

    vec("recov", 25'h0400000, 8'd100, 5'd2, 25'h1000000, 8'd98,
        1'b0, 1'b0, 1'b0, nlat(2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
